led_share_arbiter: RTL

//  Shares one board LED between NUM_REQ requesters.
//  - Round-robin grant with a minimum hold window.
//  - Drives the LED with the granted requester's latched blink mode.
//  - Timebase: a free-running prescaler tick, every 2**PRESCALE_W clocks (16 at default).
//  - Sits between status sources (error, heartbeat, activity) and the LED pin.

---
 rtl/led_ctrl_pkg.sv | 35 +++
 rtl/led_rr_pick.sv | 34 +++
 rtl/led_share_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types for the LED share arbiter.
//   led_mode_e  : per-requester blink mode (OFF, ON, SLOW, FAST)
//   arb_state_e : arbiter FSM state (IDLE, ACTIVE)
//   SLOW_DIV    : ticks per SLOW-mode toggle; PHASE_W is the width of the
//                 phase counter that wraps at SLOW_DIV
//   led_next()  : next LED level on a timebase tick for a given mode
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    ON   = 2'b01,
    SLOW = 2'b10,
    FAST = 2'b11
  } led_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_e;

  localparam int SLOW_DIV = 8;
  localparam int PHASE_W  = $clog2(SLOW_DIV);

  // slow_wrap is high on the tick where the phase counter rolls over to 0.
  function automatic logic led_next(led_mode_e m, logic cur, logic slow_wrap);
    case (m)
      OFF:     led_next = 1'b0;
      ON:      led_next = 1'b1;
      SLOW:    led_next = cur ^ slow_wrap;
      FAST:    led_next = ~cur;
      default: led_next = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/led_rr_pick.sv
// Round-robin picker, purely combinational.
//   req      : level requests
//   rr_ptr   : last granted index; search starts at rr_ptr+1 and wraps
//   excl_ptr : when high, rr_ptr itself is not a candidate (rotating away
//              from the current owner); when low it is searched last
//   winner   : chosen index (0 when nothing valid)
//   valid    : a candidate was found
module led_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  input  logic               excl_ptr,
  output logic [IDW-1:0]     winner,
  output logic               valid
);

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (req[IDW'(idx)] && !(excl_ptr && off == NUM_REQ)) begin
        winner = IDW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_share_arbiter.sv
// Shares one board LED between NUM_REQ requesters with round-robin grants,
// a minimum hold window measured in prescaler ticks, and a per-grant latched
// blink mode.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : level requests, held while the requester wants the LED
//   mode       : 2 bits per requester (00 off, 01 on, 10 slow, 11 fast)
//   gnt        : one-hot grant (registered)
//   cur_id     : granted index, 0 when idle
//   busy       : a grant is active
//   led        : LED drive (registered)
// Optional macro LED_ARB_PREEMPT_EN: requester 0 pre-empts any other owner
// regardless of hold, and keeps the LED (no rotation) until it drops req.
module led_share_arbiter
  import led_ctrl_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int PRESCALE_W = 4,
  parameter  int MIN_HOLD   = 8,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] mode,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [IDW-1:0]       cur_id,
  output logic                 busy,
  output logic                 led
);

  localparam int HOLD_W = $clog2(MIN_HOLD + 1);

  arb_state_e                   state;
  logic [IDW-1:0]               rr_ptr;
  led_mode_e                    cur_mode;
  logic [HOLD_W-1:0]            hold;
  logic [PHASE_W-1:0]           phase;
  logic [PRESCALE_W-1:0]        prescaler;
  logic [NUM_REQ-1:0][1:0]      mode_a;

  logic                         tick;
  logic [IDW-1:0]               pick_id;
  logic                         pick_vld;
  logic                         release_g;
  logic                         load;
  logic [IDW-1:0]               nid;
  led_mode_e                    nmode;
  logic                         preempt;
  logic                         owner0_lock;

  assign mode_a    = mode;
  assign tick      = &prescaler;
  assign release_g = (state == ACTIVE) && !req[cur_id];
  assign nmode     = led_mode_e'(mode_a[nid]);

`ifdef LED_ARB_PREEMPT_EN
  assign preempt     = req[0] && (cur_id != '0);
  assign owner0_lock = (cur_id == '0);
`else
  assign preempt     = 1'b0;
  assign owner0_lock = 1'b0;
`endif

  // In ACTIVE rr_ptr equals the owner, so excluding it skips the owner.
  led_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .excl_ptr (state == ACTIVE),
    .winner   (pick_id),
    .valid    (pick_vld)
  );

  // Decide whether a (new) grant is loaded this edge and to whom.
  always_comb begin
    load = 1'b0;
    nid  = pick_id;
    if (state == IDLE) begin
      load = pick_vld;
    end else if (req[cur_id]) begin
      if (preempt) begin
        load = 1'b1;
        nid  = '0;
      end else if (hold >= HOLD_W'(MIN_HOLD) && pick_vld && !owner0_lock) begin
        load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      cur_id    <= '0;
      busy      <= 1'b0;
      led       <= 1'b0;
      rr_ptr    <= IDW'(NUM_REQ - 1);
      cur_mode  <= OFF;
      hold      <= '0;
      phase     <= '0;
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
      if (release_g) begin
        state  <= IDLE;
        gnt    <= '0;
        cur_id <= '0;
        busy   <= 1'b0;
        led    <= 1'b0;
      end else if (load) begin
        // A coincident tick is deliberately dropped for the new grant.
        state      <= ACTIVE;
        gnt        <= '0;
        gnt[nid]   <= 1'b1;
        cur_id     <= nid;
        rr_ptr     <= nid;
        cur_mode   <= nmode;
        hold       <= '0;
        phase      <= '0;
        busy       <= 1'b1;
        led        <= (nmode != OFF);
      end else if (state == ACTIVE && tick) begin
        if (hold < HOLD_W'(MIN_HOLD))
          hold <= hold + 1'b1;
        phase <= phase + 1'b1;
        led   <= led_next(cur_mode, led, phase == PHASE_W'(SLOW_DIV - 1));
      end
    end
  end

endmodule
